// File: rtl/serial_pattern_tx.sv
// serial_pattern_tx
// Takes parallel words over a valid/ready handshake and shifts them out
// MSB-first, one bit per clock. Also keeps saturating reference counts of
// the "101" and "010" patterns in the emitted stream, so a checker can
// compare them against the pattern detector's pulses.
module serial_pattern_tx #(
    parameter int       WIDTH      = 10,
    parameter int       CNT_W      = 8,
    parameter logic     IDLE_LEVEL = 1'b0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             done,
    input  logic             clear_counts,
    output logic [CNT_W-1:0] count_101,
    output logic [CNT_W-1:0] count_010
);

    // Index of the bit currently on the line; WIDTH >= 2 keeps this >= 1 bit.
    localparam int               IDX_W    = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    // Pattern slots: 0 counts "101", 1 counts "010".
    localparam int         NUM_PAT = 2;
    localparam logic [2:0] PAT_101 = 3'b101;
    localparam logic [2:0] PAT_010 = 3'b010;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t               state_q;
    logic [WIDTH-1:0]     shreg_q;
    logic [IDX_W-1:0]     bit_idx_q;
    logic                 serial_out_q;
    logic                 serial_valid_q;
    logic                 done_q;

    logic                 h1_q;
    logic                 h2_q;
    logic [1:0]           fill_q;

    logic [CNT_W-1:0]     cnt_q [NUM_PAT];
    logic [NUM_PAT-1:0]   pat_hit;
    logic [2:0]           window;
    logic                 hist_full;
    logic                 last_bit;
    logic                 handshake;

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    // Ready while idle, or on the last bit so the next word follows with no
    // gap. Held low during reset so nothing is accepted on a reset edge.
    assign last_bit   = (state_q == SHIFT) && (bit_idx_q == '0);
    assign load_ready = ~reset & ((state_q == IDLE) | last_bit);
    assign handshake  = load_valid & load_ready;

    // ------------------------------------------------------------------
    // Shift FSM
    // ------------------------------------------------------------------
    // Single-block FSM; outputs are registered and always describe the bit
    // that the shift register will present after this edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= IDLE;
            shreg_q        <= '0;
            bit_idx_q      <= '0;
            serial_out_q   <= IDLE_LEVEL;
            serial_valid_q <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (handshake) begin
                        state_q        <= SHIFT;
                        shreg_q        <= data;
                        bit_idx_q      <= LAST_IDX;
                        serial_out_q   <= data[WIDTH-1];
                        serial_valid_q <= 1'b1;
                        done_q         <= 1'b0;
                    end else begin
                        serial_out_q   <= IDLE_LEVEL;
                        serial_valid_q <= 1'b0;
                        done_q         <= 1'b0;
                    end
                end

                SHIFT: begin
                    if (bit_idx_q == '0) begin
                        if (handshake) begin
                            // Back-to-back word: reload without leaving SHIFT.
                            state_q        <= SHIFT;
                            shreg_q        <= data;
                            bit_idx_q      <= LAST_IDX;
                            serial_out_q   <= data[WIDTH-1];
                            serial_valid_q <= 1'b1;
                            done_q         <= 1'b0;
                        end else begin
                            state_q        <= IDLE;
                            shreg_q        <= shreg_q << 1;
                            bit_idx_q      <= '0;
                            serial_out_q   <= IDLE_LEVEL;
                            serial_valid_q <= 1'b0;
                            done_q         <= 1'b0;
                        end
                    end else begin
                        shreg_q        <= shreg_q << 1;
                        bit_idx_q      <= bit_idx_q - IDX_W'(1);
                        serial_out_q   <= shreg_q[WIDTH-2];
                        serial_valid_q <= 1'b1;
                        done_q         <= (bit_idx_q == IDX_W'(1));
                    end
                end

                default: begin
                    state_q        <= IDLE;
                    serial_out_q   <= IDLE_LEVEL;
                    serial_valid_q <= 1'b0;
                    done_q         <= 1'b0;
                end
            endcase
        end
    end

    assign serial_out   = serial_out_q;
    assign serial_valid = serial_valid_q;
    assign done         = done_q;

    // ------------------------------------------------------------------
    // Pattern history
    // ------------------------------------------------------------------
    // Two-bit history of emitted bits. Any idle cycle empties it, so a
    // pattern can never straddle a gap, while back-to-back words share it.
    always_ff @(posedge clock) begin
        if (reset) begin
            h1_q   <= 1'b0;
            h2_q   <= 1'b0;
            fill_q <= 2'd0;
        end else if (serial_valid_q) begin
            h2_q <= h1_q;
            h1_q <= serial_out_q;
            if (fill_q != 2'd2) begin
                fill_q <= fill_q + 2'd1;
            end
        end else begin
            fill_q <= 2'd0;
        end
    end

    // Three-bit window ending with the bit currently on the line.
    assign window    = {h2_q, h1_q, serial_out_q};
    assign hist_full = serial_valid_q && (fill_q == 2'd2);

    // Combinational match of the current window against each pattern.
    always_comb begin
        pat_hit    = '0;
        pat_hit[0] = hist_full && (window == PAT_101);
        pat_hit[1] = hist_full && (window == PAT_010);
    end

    // ------------------------------------------------------------------
    // Saturating counters
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NUM_PAT; gi++) begin : g_cnt
            // Count matches for pattern gi; clear overrides a same-cycle hit.
            always_ff @(posedge clock) begin
                if (reset || clear_counts) begin
                    cnt_q[gi] <= '0;
                end else if (pat_hit[gi] && (cnt_q[gi] != CNT_MAX)) begin
                    cnt_q[gi] <= cnt_q[gi] + CNT_W'(1);
                end
            end
        end
    endgenerate

    assign count_101 = cnt_q[0];
    assign count_010 = cnt_q[1];

endmodule
